// File: rtl/apb_pkg.sv
// Shared APB definitions: initiator FSM states, bus widths and ADC bridge register offsets.
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_state_e;

    localparam int unsigned APB_ADDR_W = 12;
    localparam int unsigned APB_DATA_W = 32;

    localparam logic [APB_ADDR_W-1:0] ADC_SAMPLE_EN  = 12'h000;
    localparam logic [APB_ADDR_W-1:0] ADC_ADC2TMU_EN = 12'h001;

endpackage

// File: rtl/apb_initiator.sv
// Single-beat APB initiator: command channel in, APB transfer out, response channel back.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state_q, state_d;
    logic              rdy_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;

    // Counter is cleared during SETUP so it starts at zero on ACCESS entry.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (state_q == StSetup) begin
            cnt_q <= '0;
        end else if (state_q == StAccess && !PREADY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == StAccess) && !PREADY &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= StIdle;
            rdy_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (state_q == StIdle && cmd_valid && cmd_ready) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_write ? cmd_wdata : '0;
            end
            if (state_q == StAccess && PREADY) begin
                rdata_q <= write_q ? '0 : PRDATA;
                err_q   <= PSLVERR;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Handshake outputs decode straight from state_q so reset drops PSEL/PENABLE at once.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = rdy_q;
                if (cmd_valid && rdy_q) state_d = StSetup;
            end
            StSetup: begin
                PSEL    = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timeout_hit) state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: directed vector table, random transfers against a
// transaction-level model, plus reset-abort and ACCESS timeout sequences.
module tb_apb_initiator;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [DW-1:0] PWDATA, PRDATA;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_initiator #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            rdly;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what the responder returns, independent of cycle detail.
    function automatic logic [DW-1:0] ref_rdata(input logic wr, input logic [DW-1:0] prdata);
        return wr ? '0 : prdata;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 8 && !cmd_ready; i++) step();
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        wait_ready();
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
    endtask

    task automatic run_xfer(input vec_t v);
        logic [DW-1:0] exp_pw;
        exp_pw = v.wr ? v.wdata : '0;
        issue(v.wr, v.addr, v.wdata);
        // SETUP: handshake cycle was 0, this is cycle 1
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.wr);
        chk("setup_pwdata", PWDATA, exp_pw);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_busy", busy, 1);
        PREADY = 1'b0;
        step();
        for (int a = 0; a <= v.waits; a++) begin
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, v.addr);
            chk("access_pwrite", PWRITE, v.wr);
            chk("access_pwdata", PWDATA, exp_pw);
            chk("access_cmd_ready", cmd_ready, 0);
            chk("access_rsp_valid", rsp_valid, 0);
            PREADY  = (a == v.waits);
            PRDATA  = PREADY ? v.prdata : $urandom;
            PSLVERR = PREADY ? v.slverr : 1'($urandom);
            step();
        end
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
        for (int d = 0; d <= v.rdly; d++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_rdata", rsp_rdata, v.exp_rdata);
            chk("resp_err", rsp_err, v.exp_err);
            chk("resp_psel", PSEL, 0);
            chk("resp_penable", PENABLE, 0);
            chk("resp_cmd_ready", cmd_ready, 0);
            rsp_ready = (d == v.rdly);
            step();
        end
        rsp_ready = 1'b0;
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        vec_t rv;
        int   cnt;

        PRESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 0; PREADY = 0; PSLVERR = 0; PRDATA = '0;

        vecs[0] = '{1'b0, 12'h000, 32'h0, 0, 32'h0000_0ABC, 1'b0, 0, 32'h0000_0ABC, 1'b0};
        vecs[1] = '{1'b1, 12'h001, 32'h1, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 12'h5A5, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 12'h7FF, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 5, 32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b1, 12'hFFF, 32'hA5A5_5A5A, 2, 32'h7777_7777, 1'b1, 1, 32'h0, 1'b1};
        vecs[5] = '{1'b0, 12'h001, 32'h0, 1, 32'h8000_0001, 1'b0, 2, 32'h8000_0001, 1'b0};

        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        #11 PRESETn = 1'b1;
        step();
        step();

        foreach (vecs[i]) run_xfer(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            rv.wr        = 1'($urandom);
            rv.addr      = AW'($urandom);
            rv.wdata     = $urandom;
            rv.waits     = int'($urandom_range(0, 3));
            rv.prdata    = $urandom;
            rv.slverr    = 1'($urandom);
            rv.rdly      = int'($urandom_range(0, 2));
            rv.exp_rdata = ref_rdata(rv.wr, rv.prdata);
            rv.exp_err   = rv.slverr;
            run_xfer(rv);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        // Reset pulsed mid-ACCESS: bus drops immediately, transfer discarded.
        issue(1'b0, 12'h123, '0);
        PREADY = 1'b0;
        step();
        chk("rstmid_penable_before", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rstmid_psel", PSEL, 0);
        chk("rstmid_penable", PENABLE, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_cmd_ready", cmd_ready, 0);
        PREADY = 1'b1;
        step();
        #2 PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_no_rsp", rsp_valid, 0);
        end
        PREADY = 1'b0;
        chk("rstmid_cmd_ready_after", cmd_ready, 1);

        // PREADY stuck low.
        PSLVERR = 1'b0;
        PRDATA  = 32'h0000_5555;
        issue(1'b0, 12'h0F0, '0);
        PREADY = 1'b0;
        step();
`ifdef APB_TIMEOUT_EN
        cnt = 0;
        while (PENABLE && cnt < 40) begin
            cnt++;
            step();
        end
        chk("timeout_access_cycles", 32'(cnt), TO);
        chk("timeout_rsp_valid", rsp_valid, 1);
        chk("timeout_rsp_err", rsp_err, 1);
        chk("timeout_rsp_rdata", rsp_rdata, 0);
        chk("timeout_psel", PSEL, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("timeout_cmd_ready", cmd_ready, 1);
        // PREADY arriving on the limit cycle completes normally.
        rv = '{1'b0, 12'h010, 32'h0, TO - 1, 32'h0000_0055, 1'b0, 0, 32'h0000_0055, 1'b0};
        run_xfer(rv);
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) step();
        chk("nowait_limit_penable", PENABLE, 1);
        chk("nowait_limit_psel", PSEL, 1);
        PREADY = 1'b1;
        step();
        PREADY = 1'b0;
        chk("nowait_limit_rsp_valid", rsp_valid, 1);
        chk("nowait_limit_rsp_err", rsp_err, 0);
        chk("nowait_limit_rsp_rdata", rsp_rdata, 32'h0000_5555);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("nowait_limit_cmd_ready", cmd_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
